// File: rtl/rv32i_enc_pkg.sv
// ============================================================================
//  Module   : rv32i_enc_pkg
//  Brief    : Mnemonic codes, opcode/funct constants and format lookup for
//             the RV32I instruction encoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_enc_pkg;

    typedef enum logic [5:0] {
        OP_LUI   = 6'd0,  OP_AUIPC = 6'd1,  OP_JAL   = 6'd2,  OP_JALR  = 6'd3,
        OP_BEQ   = 6'd4,  OP_BNE   = 6'd5,  OP_BLT   = 6'd6,  OP_BGE   = 6'd7,
        OP_BLTU  = 6'd8,  OP_BGEU  = 6'd9,  OP_LB    = 6'd10, OP_LH    = 6'd11,
        OP_LW    = 6'd12, OP_LBU   = 6'd13, OP_LHU   = 6'd14, OP_SB    = 6'd15,
        OP_SH    = 6'd16, OP_SW    = 6'd17, OP_ADDI  = 6'd18, OP_SLTI  = 6'd19,
        OP_SLTIU = 6'd20, OP_XORI  = 6'd21, OP_ORI   = 6'd22, OP_ANDI  = 6'd23,
        OP_SLLI  = 6'd24, OP_SRLI  = 6'd25, OP_SRAI  = 6'd26, OP_ADD   = 6'd27,
        OP_SUB   = 6'd28, OP_SLL   = 6'd29, OP_SLT   = 6'd30, OP_SLTU  = 6'd31,
        OP_XOR   = 6'd32, OP_SRL   = 6'd33, OP_SRA   = 6'd34, OP_OR    = 6'd35,
        OP_AND   = 6'd36
    } enc_op_t;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_SH  = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_BAD = 3'd7
    } enc_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } enc_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_MEMB  = 3'b000;
    localparam logic [2:0] F3_MEMH  = 3'b001;
    localparam logic [2:0] F3_MEMW  = 3'b010;
    localparam logic [2:0] F3_MEMBU = 3'b100;
    localparam logic [2:0] F3_MEMHU = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        enc_fmt_t   fmt;
        logic [6:0] opcode;
        logic [2:0] fn3;
        logic [6:0] fn7;
    } enc_info_t;

    function automatic enc_info_t mk_info(input enc_fmt_t fmt, input logic [6:0] opcode,
                                          input logic [2:0] fn3, input logic [6:0] fn7);
        enc_info_t r;
        r.fmt    = fmt;
        r.opcode = opcode;
        r.fn3    = fn3;
        r.fn7    = fn7;
        return r;
    endfunction

    // Codes >= 37 map to FMT_BAD, which the encoder reports as an illegal op.
    function automatic enc_info_t op_info(input logic [5:0] op);
        enc_info_t r;
        r = mk_info(FMT_BAD, 7'b0, 3'b0, F7_BASE);
        case (op)
            OP_LUI:   r = mk_info(FMT_U,  OPC_LUI,    F3_ADD,   F7_BASE);
            OP_AUIPC: r = mk_info(FMT_U,  OPC_AUIPC,  F3_ADD,   F7_BASE);
            OP_JAL:   r = mk_info(FMT_J,  OPC_JAL,    F3_ADD,   F7_BASE);
            OP_JALR:  r = mk_info(FMT_I,  OPC_JALR,   F3_ADD,   F7_BASE);
            OP_BEQ:   r = mk_info(FMT_B,  OPC_BRANCH, F3_BEQ,   F7_BASE);
            OP_BNE:   r = mk_info(FMT_B,  OPC_BRANCH, F3_BNE,   F7_BASE);
            OP_BLT:   r = mk_info(FMT_B,  OPC_BRANCH, F3_BLT,   F7_BASE);
            OP_BGE:   r = mk_info(FMT_B,  OPC_BRANCH, F3_BGE,   F7_BASE);
            OP_BLTU:  r = mk_info(FMT_B,  OPC_BRANCH, F3_BLTU,  F7_BASE);
            OP_BGEU:  r = mk_info(FMT_B,  OPC_BRANCH, F3_BGEU,  F7_BASE);
            OP_LB:    r = mk_info(FMT_I,  OPC_LOAD,   F3_MEMB,  F7_BASE);
            OP_LH:    r = mk_info(FMT_I,  OPC_LOAD,   F3_MEMH,  F7_BASE);
            OP_LW:    r = mk_info(FMT_I,  OPC_LOAD,   F3_MEMW,  F7_BASE);
            OP_LBU:   r = mk_info(FMT_I,  OPC_LOAD,   F3_MEMBU, F7_BASE);
            OP_LHU:   r = mk_info(FMT_I,  OPC_LOAD,   F3_MEMHU, F7_BASE);
            OP_SB:    r = mk_info(FMT_S,  OPC_STORE,  F3_MEMB,  F7_BASE);
            OP_SH:    r = mk_info(FMT_S,  OPC_STORE,  F3_MEMH,  F7_BASE);
            OP_SW:    r = mk_info(FMT_S,  OPC_STORE,  F3_MEMW,  F7_BASE);
            OP_ADDI:  r = mk_info(FMT_I,  OPC_OP_IMM, F3_ADD,   F7_BASE);
            OP_SLTI:  r = mk_info(FMT_I,  OPC_OP_IMM, F3_SLT,   F7_BASE);
            OP_SLTIU: r = mk_info(FMT_I,  OPC_OP_IMM, F3_SLTU,  F7_BASE);
            OP_XORI:  r = mk_info(FMT_I,  OPC_OP_IMM, F3_XOR,   F7_BASE);
            OP_ORI:   r = mk_info(FMT_I,  OPC_OP_IMM, F3_OR,    F7_BASE);
            OP_ANDI:  r = mk_info(FMT_I,  OPC_OP_IMM, F3_AND,   F7_BASE);
            OP_SLLI:  r = mk_info(FMT_SH, OPC_OP_IMM, F3_SLL,   F7_BASE);
            OP_SRLI:  r = mk_info(FMT_SH, OPC_OP_IMM, F3_SR,    F7_BASE);
            OP_SRAI:  r = mk_info(FMT_SH, OPC_OP_IMM, F3_SR,    F7_ALT);
            OP_ADD:   r = mk_info(FMT_R,  OPC_OP,     F3_ADD,   F7_BASE);
            OP_SUB:   r = mk_info(FMT_R,  OPC_OP,     F3_ADD,   F7_ALT);
            OP_SLL:   r = mk_info(FMT_R,  OPC_OP,     F3_SLL,   F7_BASE);
            OP_SLT:   r = mk_info(FMT_R,  OPC_OP,     F3_SLT,   F7_BASE);
            OP_SLTU:  r = mk_info(FMT_R,  OPC_OP,     F3_SLTU,  F7_BASE);
            OP_XOR:   r = mk_info(FMT_R,  OPC_OP,     F3_XOR,   F7_BASE);
            OP_SRL:   r = mk_info(FMT_R,  OPC_OP,     F3_SR,    F7_BASE);
            OP_SRA:   r = mk_info(FMT_R,  OPC_OP,     F3_SR,    F7_ALT);
            OP_OR:    r = mk_info(FMT_R,  OPC_OP,     F3_OR,    F7_BASE);
            OP_AND:   r = mk_info(FMT_R,  OPC_OP,     F3_AND,   F7_BASE);
            default:  r = mk_info(FMT_BAD, 7'b0,      3'b0,     F7_BASE);
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/enc_fifo.sv
// ============================================================================
//  Module   : enc_fifo
//  Brief    : Synchronous FIFO with wrap-bit pointers buffering encoded words.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      wr_ptr_q;
    logic [PW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // The extra MSB distinguishes full from empty when the index bits match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;
    assign rdata_o   = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/rv32i_instr_encoder.sv
// ============================================================================
//  Module   : rv32i_instr_encoder
//  Brief    : Encodes mnemonic + operands into RV32I words and streams them to
//             IMEM at sequential addresses. Optional IMM_RANGE_CHECK_EN drops
//             requests whose immediate does not fit its format.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_instr_encoder
    import rv32i_enc_pkg::*;
#(
    parameter int             DEPTH     = 8,
    parameter int             AW        = 32,
    parameter logic [AW-1:0]  BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] start_addr_i,
    input  logic          finish_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [5:0]    req_op_i,
    input  logic [4:0]    req_rd_i,
    input  logic [4:0]    req_rs1_i,
    input  logic [4:0]    req_rs2_i,
    input  logic [31:0]   req_imm_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] out_addr_o,
    output logic [31:0]   out_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int                   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]        CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    enc_state_t    state_q;
    logic [AW-1:0] addr_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    enc_info_t     w_info;
    logic          w_ok;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_word;
    logic [31:0]   w_head;
    logic          w_last_out;

    function automatic logic [31:0] encode(input enc_info_t inf, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        logic [31:0] w;
        w = '0;
        case (inf.fmt)
            FMT_R:   w = {inf.fn7, rs2, rs1, inf.fn3, rd, inf.opcode};
            FMT_I:   w = {imm[11:0], rs1, inf.fn3, rd, inf.opcode};
            FMT_SH:  w = {inf.fn7, imm[4:0], rs1, inf.fn3, rd, inf.opcode};
            FMT_S:   w = {imm[11:5], rs2, rs1, inf.fn3, imm[4:0], inf.opcode};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, inf.fn3, imm[4:1], imm[11], inf.opcode};
            FMT_U:   w = {imm[31:12], rd, inf.opcode};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, inf.opcode};
            default: w = '0;
        endcase
        return w;
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    function automatic logic imm_fits(input enc_fmt_t fmt, input logic [31:0] imm);
        logic ok;
        ok = 1'b1;
        case (fmt)
            FMT_I, FMT_S: ok = (imm[31:11] == '0) || (imm[31:11] == '1);
            FMT_SH:       ok = (imm[31:5] == '0);
            FMT_B:        ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
            FMT_J:        ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
            FMT_U:        ok = (imm[11:0] == '0);
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction

    assign w_ok = (w_info.fmt != FMT_BAD) && imm_fits(w_info.fmt, req_imm_i);
`else
    assign w_ok = (w_info.fmt != FMT_BAD);
`endif

    assign w_info      = op_info(req_op_i);
    assign w_word      = encode(w_info, req_rd_i, req_rs1_i, req_rs2_i, req_imm_i);
    assign req_ready_o = (state_q == ST_RUN) && !w_full;
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_push      = w_accept && w_ok;
    assign out_valid_o = !w_empty;
    assign w_pop       = out_valid_o && out_ready_i;
    // Leave DRAIN on the edge that retires the final word so done aligns with IDLE.
    assign w_last_out  = w_empty || (w_pop && (w_count == CNT_ONE));

    assign out_addr_o  = addr_q;
    assign out_data_o  = w_empty ? 32'd0 : w_head;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_word),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_ADDR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= w_accept && !w_ok;
            if (w_pop) addr_q <= addr_q + AW'(4);
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        addr_q  <= start_addr_i & ~AW'(3);
                    end
                end
                ST_RUN: begin
                    if (finish_i) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_last_out) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_instr_encoder.sv
// ============================================================================
//  Module   : tb_rv32i_instr_encoder
//  Brief    : Directed vectors with a queue scoreboard and an output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_instr_encoder;

    localparam logic [5:0] T_LUI = 6'd0, T_AUIPC = 6'd1, T_JAL = 6'd2, T_JALR = 6'd3;
    localparam logic [5:0] T_BEQ = 6'd4, T_LW = 6'd12, T_SW = 6'd17, T_ADDI = 6'd18;
    localparam logic [5:0] T_SRAI = 6'd26, T_SUB = 6'd28, T_AND = 6'd36;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic        finish = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] tb_addr = '0;
    logic        e;

    rv32i_instr_encoder #(
        .DEPTH     (8),
        .AW        (32),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .start_addr_i (start_addr),
        .finish_i     (finish),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_rd_i     (req_rd),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_imm_i    (req_imm),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_addr_o   (out_addr),
        .out_data_o   (out_data),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every IMEM handshake, checks hold while stalled.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    exp_t        m_exp;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                chk("hold_addr", out_addr, prev_addr);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h @%h expected none", out_data, out_addr);
                end else begin
                    m_exp = sb_q.pop_front();
                    chk("out_addr", out_addr, m_exp.addr);
                    chk("out_data", out_data, m_exp.data);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_addr  = out_addr;
            prev_data  = out_data;
        end
    end

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic expect_word, input logic [31:0] exp_data,
                        output logic err_seen);
        int n;
        @(posedge clk);
        #1;
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            req_valid = 1'b0;
            err_seen = 1'b0;
            return;
        end
        if (expect_word) begin
            sb_q.push_back('{addr: tb_addr, data: exp_data});
            tb_addr = tb_addr + 32'd4;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        err_seen = err;
    endtask

    task automatic start_prog(input logic [31:0] a);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a;
        @(posedge clk); #1;
        start = 1'b0;
        tb_addr = a & ~32'd3;
    endtask

    task automatic finish_prog();
        @(posedge clk); #1;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk(name, {31'd0, got}, 32'd1);
        if (got) begin
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            chk("valid_at_done", {31'd0, out_valid}, 32'd0);
            chk("sb_empty_at_done", sb_q.size(), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_err",       {31'd0, err},       32'd0);
        chk("rst_out_addr",  out_addr,           32'h0);
        chk("rst_out_data",  out_data,           32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed encodings, out_ready always high
        out_ready = 1'b1;
        start_prog(32'h100);
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("valid_before_req", {31'd0, out_valid}, 32'd0);
        send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, e);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_err", {31'd0, e}, 32'd0);
        send(T_LUI,  5'd2, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_5137, e);
        send(T_SW,   5'd0, 5'd2, 5'd5, 32'd8,         1'b1, 32'h0051_2423, e);
        // start while running must not move the address counter
        @(posedge clk); #1; start = 1'b1; start_addr = 32'h800;
        @(posedge clk); #1; start = 1'b0;
        send(T_SUB,  5'd3, 5'd1, 5'd2, 32'd0,         1'b1, 32'h4020_81B3, e);
        send(T_JAL,  5'd1, 5'd0, 5'd0, 32'd8,         1'b1, 32'h0080_00EF, e);
        send(T_BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3, e);
        send(T_SRAI, 5'd4, 5'd5, 5'd0, 32'd3,         1'b1, 32'h4032_D213, e);
        send(T_LW,   5'd6, 5'd7, 5'd0, 32'hFFFF_FFF8, 1'b1, 32'hFF83_A303, e);
        send(T_AUIPC,5'd10,5'd0, 5'd0, 32'h0000_1000, 1'b1, 32'h0000_1517, e);
        send(T_JALR, 5'd0, 5'd1, 5'd0, 32'd0,         1'b1, 32'h0000_8067, e);
        send(T_AND,  5'd5, 5'd6, 5'd7, 32'd0,         1'b1, 32'h0073_72B3, e);
        chk("and_err", {31'd0, e}, 32'd0);
        send(6'd40,  5'd1, 5'd1, 5'd1, 32'd1,         1'b0, 32'h0,         e);
        chk("illegal_err", {31'd0, e}, 32'd1);
        @(posedge clk); #1;
        chk("err_one_cycle", {31'd0, err}, 32'd0);
`ifdef IMM_RANGE_CHECK_EN
        send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0, e);
        chk("imm_range_err", {31'd0, e}, 32'd1);
`else
        send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h8000_0093, e);
        chk("imm_trunc_err", {31'd0, e}, 32'd0);
`endif
        finish_prog();
        wait_done("done_prog1");

        // Fill the FIFO with IMEM stalled, then release
        out_ready = 1'b0;
        start_prog(32'h103);
        for (int k = 1; k <= 8; k++) begin
            send(T_ADDI, 5'(k), 5'd0, 5'd0, 32'(k), 1'b1,
                 (32'(k) << 20) | (32'(k) << 7) | 32'h13, e);
        end
        chk("full_ready_low", {31'd0, req_ready}, 32'd0);
        chk("full_head_addr", out_addr, 32'h100);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        finish_prog();
        wait_done("done_full");

        // Address wrap at the top of the space
        start_prog(32'hFFFF_FFFC);
        send(T_AND,  5'd5, 5'd6, 5'd7, 32'd0, 1'b1, 32'h0073_72B3, e);
        send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, e);
        finish_prog();
        wait_done("done_wrap");

        // Drain with three queued words
        out_ready = 1'b0;
        start_prog(32'h200);
        send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, e);
        send(T_SUB,  5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h4020_81B3, e);
        send(T_JAL,  5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h0080_00EF, e);
        finish_prog();
        repeat (2) @(posedge clk);
        #1;
        chk("busy_drain_stalled", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        wait_done("done_drain");

        // Reset in the middle of a drain
        out_ready = 1'b0;
        start_prog(32'h300);
        send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, e);
        send(T_LUI,  5'd2, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_5137, e);
        finish_prog();
        @(posedge clk); #2;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy",  {31'd0, busy},      32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_addr",  out_addr,           32'h0);
        chk("midrst_data",  out_data,           32'h0);
        rst = 1'b0;

        // Recovery after reset
        out_ready = 1'b1;
        start_prog(32'h40);
        send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, e);
        finish_prog();
        wait_done("done_after_rst");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
